// File: rtl/net_run_controller.sv
// net_run_controller: sequences RESET, WARMUP, MEASURE and COOLDOWN phases of an
// emulation run and counts packets injected/ejected inside the measurement window.
`default_nettype none

module net_run_controller #(
    parameter int PORTS           = 8,
    parameter int RESET_CYCLES    = 10,
    parameter int WARMUP_CYCLES   = 1000,
    parameter int MEASURE_CYCLES  = 10000,
    parameter int COOLDOWN_CYCLES = 2000,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [PORTS-1:0] inj_valid,
    input  logic [PORTS-1:0] ej_valid,
    output logic             net_rst,
    output logic             source_on,
    output logic             measure,
    output logic             busy,
    output logic             done,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] inj_count,
    output logic [CNT_W-1:0] ej_count
);

    localparam int MAX_RW  = (RESET_CYCLES > WARMUP_CYCLES) ? RESET_CYCLES : WARMUP_CYCLES;
    localparam int MAX_MC  = (MEASURE_CYCLES > COOLDOWN_CYCLES) ? MEASURE_CYCLES : COOLDOWN_CYCLES;
    localparam int MAX_CYC = (MAX_RW > MAX_MC) ? MAX_RW : MAX_MC;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0] LD_RESET    = TW'(RESET_CYCLES - 1);
    localparam logic [TW-1:0] LD_WARMUP   = TW'(WARMUP_CYCLES - 1);
    localparam logic [TW-1:0] LD_MEASURE  = TW'(MEASURE_CYCLES - 1);
    localparam logic [TW-1:0] LD_COOLDOWN = TW'(COOLDOWN_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RESET    = 3'd1,
        ST_WARMUP   = 3'd2,
        ST_MEASURE  = 3'd3,
        ST_COOLDOWN = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [CNT_W-1:0] inj_count_q, inj_count_d;
    logic [CNT_W-1:0] ej_count_q, ej_count_d;
    logic             net_rst_q, net_rst_d;
    logic             source_on_q, source_on_d;
    logic             measure_q, measure_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             abort_hit;
    logic             launch;

    function automatic logic [CNT_W:0] popcount(input logic [PORTS-1:0] v);
        logic [CNT_W:0] pc;
        pc = '0;
        for (int i = 0; i < PORTS; i++) begin
            pc = pc + {{CNT_W{1'b0}}, v[i]};
        end
        return pc;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W:0]   b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + b;
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        inj_count_d = inj_count_q;
        ej_count_d  = ej_count_q;

        abort_hit = abort && (state_q != ST_IDLE);
        launch    = start && !abort_hit && ((state_q == ST_IDLE) || (state_q == ST_DONE));

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RESET;
                    tmr_d   = LD_RESET;
                end
            end
            ST_RESET: begin
                if (tmr_q == '0) begin
                    state_d = ST_WARMUP;
                    tmr_d   = LD_WARMUP;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            ST_WARMUP: begin
                if (tmr_q == '0) begin
                    state_d = ST_MEASURE;
                    tmr_d   = LD_MEASURE;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            ST_MEASURE: begin
                if (tmr_q == '0) begin
                    state_d = ST_COOLDOWN;
                    tmr_d   = LD_COOLDOWN;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            ST_COOLDOWN: begin
                if (tmr_q == '0) begin
                    state_d = ST_DONE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort_hit) begin
            state_d = ST_IDLE;
            tmr_d   = '0;
        end

        // Counting follows the current state even on the aborting edge.
        if (launch) begin
            inj_count_d = '0;
            ej_count_d  = '0;
        end else begin
            if (state_q == ST_MEASURE) begin
                inj_count_d = sat_add(inj_count_q, popcount(inj_valid));
            end
            if ((state_q == ST_MEASURE) || (state_q == ST_COOLDOWN)) begin
                ej_count_d = sat_add(ej_count_q, popcount(ej_valid));
            end
        end

        // Outputs are decoded from the next state so the registers track the state register.
        net_rst_d   = (state_d == ST_IDLE) || (state_d == ST_RESET);
        source_on_d = (state_d == ST_WARMUP) || (state_d == ST_MEASURE);
        measure_d   = (state_d == ST_MEASURE) || (state_d == ST_COOLDOWN);
        busy_d      = (state_d == ST_RESET) || (state_d == ST_WARMUP) ||
                      (state_d == ST_MEASURE) || (state_d == ST_COOLDOWN);
        done_d      = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tmr_q       <= '0;
            inj_count_q <= '0;
            ej_count_q  <= '0;
            net_rst_q   <= 1'b1;
            source_on_q <= 1'b0;
            measure_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            inj_count_q <= inj_count_d;
            ej_count_q  <= ej_count_d;
            net_rst_q   <= net_rst_d;
            source_on_q <= source_on_d;
            measure_q   <= measure_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign net_rst   = net_rst_q;
    assign source_on = source_on_q;
    assign measure   = measure_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign phase     = state_q;
    assign inj_count = inj_count_q;
    assign ej_count  = ej_count_q;

endmodule

`default_nettype wire

// File: tb/tb_net_run_controller.sv
// Scoreboard bench for net_run_controller: expected per-cycle snapshots are queued
// by the stimulus process and popped/compared by a negedge monitor.
`default_nettype none

module tb_net_run_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [3:0]  inj_valid;
    logic [3:0]  ej_valid;

    logic        net_rst, source_on, measure, busy, done;
    logic [2:0]  phase;
    logic [31:0] inj_count, ej_count;

    logic        net_rst4, source_on4, measure4, busy4, done4;
    logic [2:0]  phase4;
    logic [3:0]  inj_count4, ej_count4;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        int          cyc;
        string       name;
        logic [2:0]  ph;
        logic        nr, src, ms, bs, dn;
        logic [31:0] inj, ej;
        logic [3:0]  inj4;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    net_run_controller #(
        .PORTS(4), .RESET_CYCLES(2), .WARMUP_CYCLES(3),
        .MEASURE_CYCLES(4), .COOLDOWN_CYCLES(2), .CNT_W(32)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .inj_valid(inj_valid), .ej_valid(ej_valid),
        .net_rst(net_rst), .source_on(source_on), .measure(measure),
        .busy(busy), .done(done), .phase(phase),
        .inj_count(inj_count), .ej_count(ej_count)
    );

    net_run_controller #(
        .PORTS(4), .RESET_CYCLES(2), .WARMUP_CYCLES(3),
        .MEASURE_CYCLES(4), .COOLDOWN_CYCLES(2), .CNT_W(4)
    ) dut4 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .inj_valid(inj_valid), .ej_valid(ej_valid),
        .net_rst(net_rst4), .source_on(source_on4), .measure(measure4),
        .busy(busy4), .done(done4), .phase(phase4),
        .inj_count(inj_count4), .ej_count(ej_count4)
    );

    // Snapshot for relative cycle r of a run started at cycle 0 with
    // inj_valid=4'b1111 and ej_valid=4'b0011 held constant.
    function automatic exp_t model_run(int c, int r, string nm);
        exp_t e;
        e.cyc = c; e.name = nm;
        e.ph = 3'd0; e.nr = 1'b0; e.src = 1'b0; e.ms = 1'b0; e.bs = 1'b0; e.dn = 1'b0;
        e.inj = 0; e.ej = 0;
        if (r <= 2) begin
            e.ph = 3'd1; e.nr = 1'b1; e.bs = 1'b1;
        end else if (r <= 5) begin
            e.ph = 3'd2; e.src = 1'b1; e.bs = 1'b1;
        end else if (r <= 9) begin
            e.ph = 3'd3; e.src = 1'b1; e.ms = 1'b1; e.bs = 1'b1;
            e.inj = 4 * (r - 6); e.ej = 2 * (r - 6);
        end else if (r <= 11) begin
            e.ph = 3'd4; e.ms = 1'b1; e.bs = 1'b1;
            e.inj = 16; e.ej = 2 * (r - 6);
        end else begin
            e.ph = 3'd5; e.dn = 1'b1;
            e.inj = 16; e.ej = 12;
        end
        e.inj4 = (e.inj > 15) ? 4'd15 : e.inj[3:0];
        return e;
    endfunction

    function automatic exp_t model_idle(int c, int inj, int ej, string nm);
        exp_t e;
        e.cyc = c; e.name = nm;
        e.ph = 3'd0; e.nr = 1'b1; e.src = 1'b0; e.ms = 1'b0; e.bs = 1'b0; e.dn = 1'b0;
        e.inj = inj; e.ej = ej;
        e.inj4 = (inj > 15) ? 4'd15 : 4'(inj);
        return e;
    endfunction

    task automatic goto(int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_run(int s, int first_r, int last_r, string nm);
        for (int r = first_r; r <= last_r; r++) sb.push_back(model_run(s + r, r, nm));
    endtask

    task automatic pulse_start(int c);
        goto(c); start = 1'b1;
        goto(c + 1); start = 1'b0;
    endtask

    // Monitor: compare every queued expectation that falls due this cycle.
    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                exp_t e;
                e = sb.pop_front();
                total++;
                if (e.cyc < cyc) begin
                    bad++;
                    $display("FAIL %s: expectation for cycle %0d not checked, now cycle %0d", e.name, e.cyc, cyc);
                end else if ({phase, net_rst, source_on, measure, busy, done, inj_count, ej_count, inj_count4, phase4}
                             !== {e.ph, e.nr, e.src, e.ms, e.bs, e.dn, e.inj, e.ej, e.inj4, e.ph}) begin
                    bad++;
                    $display("FAIL %s cyc=%0d: got ph=%0d nr=%b src=%b ms=%b busy=%b done=%b inj=%0d ej=%0d inj4=%0d ph4=%0d; want ph=%0d nr=%b src=%b ms=%b busy=%b done=%b inj=%0d ej=%0d inj4=%0d",
                             e.name, cyc, phase, net_rst, source_on, measure, busy, done, inj_count, ej_count, inj_count4, phase4,
                             e.ph, e.nr, e.src, e.ms, e.bs, e.dn, e.inj, e.ej, e.inj4);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        inj_valid = 4'b1111; ej_valid = 4'b0011;

        sb.push_back(model_idle(3, 0, 0, "reset_state"));
        sb.push_back(model_idle(4, 0, 0, "idle_hold"));
        goto(3); rst = 1'b0;

        // Full run from cycle 5; DONE held through cycle 19.
        push_run(5, 1, 14, "full_run");
        pulse_start(5);

        // Restart from DONE at 19, with start pulses while busy at 23 and 27.
        push_run(19, 1, 16, "restart_busy");
        sb.push_back(model_idle(36, 16, 12, "start_abort_done"));
        sb.push_back(model_idle(37, 16, 12, "idle_retain"));
        pulse_start(19);
        pulse_start(23);
        pulse_start(27);

        // Simultaneous start and abort in DONE.
        goto(35); start = 1'b1; abort = 1'b1;
        goto(36); start = 1'b0; abort = 1'b0;

        // Abort mid-MEASURE (relative cycle 7 of a run started at 38).
        push_run(38, 1, 7, "abort_run");
        sb.push_back(model_idle(46, 8, 4, "abort_idle"));
        sb.push_back(model_idle(47, 8, 4, "abort_hold"));
        pulse_start(38);
        goto(45); abort = 1'b1;
        goto(46); abort = 1'b0;

        // rst mid-COOLDOWN, then abort in IDLE is ignored.
        push_run(50, 1, 10, "rst_run");
        sb.push_back(model_idle(61, 0, 0, "rst_mid_cool"));
        sb.push_back(model_idle(62, 0, 0, "rst_idle_hold"));
        sb.push_back(model_idle(63, 0, 0, "abort_in_idle"));
        pulse_start(50);
        goto(60); rst = 1'b1;
        goto(61); rst = 1'b0;
        goto(62); abort = 1'b1;
        goto(63); abort = 1'b0;

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            bad++;
            total++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/net_run_controller.md
# net_run_controller

Run-control stage that sits directly upstream of the packet sources, packet sink and network in the emulation top level. It sequences reset, warm-up, measurement and cool-down phases in hardware, replacing the simulation-only timing control so that synthesized builds run the same experiment. It drives the network reset, source enable and measurement window. It also counts packets injected and ejected inside the window.

## Interface
Parameters:
- PORTS, 8, number of network ports
- RESET_CYCLES, 10, cycles net_rst is held in RESET phase (≥1)
- WARMUP_CYCLES, 1000, warm-up length in cycles (≥1)
- MEASURE_CYCLES, 10000, measurement length in cycles (≥1)
- COOLDOWN_CYCLES, 2000, cool-down length in cycles (≥1)
- CNT_W, 32, packet counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  pulse; begins a run from IDLE or DONE
- abort  in  1  pulse; terminates a run
- inj_valid  in  PORTS  per-port valid of packets entering the network
- ej_valid  in  PORTS  per-port valid of packets leaving the network
- net_rst  out  1  reset to the network, sources and sink
- source_on  out  1  packet source enable
- measure  out  1  measurement window to the sink
- busy  out  1  a run is in progress (RESET through COOLDOWN)
- done  out  1  run completed; counts are final
- phase  out  3  current state encoding
- inj_count  out  CNT_W  packets injected during MEASURE
- ej_count  out  CNT_W  packets ejected during MEASURE and COOLDOWN

## Operation
- FSM states and phase codes: IDLE=0, RESET=1, WARMUP=2, MEASURE=3, COOLDOWN=4, DONE=5.
- Moore outputs, decoded from the state register:
  - IDLE: net_rst=1, source_on=0, measure=0, busy=0, done=0.
  - RESET: net_rst=1, busy=1.
  - WARMUP: source_on=1.
  - MEASURE: source_on=1, measure=1.
  - COOLDOWN: source_on=0, measure=1.
  - DONE: net_rst=0, source_on=0, measure=0, done=1.
- Transitions:
  - IDLE or DONE, with start=1 → RESET; inj_count and ej_count clear to 0 on this edge.
  - Each timed phase lasts exactly its parameter's cycle count. A phase down-counter is loaded with N-1 on entry, and the FSM advances when it reads 0 and the state is still sampled.
  - Order: RESET → WARMUP → MEASURE → COOLDOWN → DONE.
- start is ignored in RESET, WARMUP, MEASURE and COOLDOWN.
- abort=1 in any state other than IDLE → IDLE on the next edge. Counts are retained. abort has priority over phase expiry and over start.
- Counting:
  - On each edge while in MEASURE, inj_count increases by popcount(inj_valid).
  - On each edge while in MEASURE or COOLDOWN, ej_count increases by popcount(ej_valid).
  - Adders are CNT_W+1 wide. Results saturate at 2^CNT_W-1 and never wrap.
  - Counts are held in all other states.

## Timing
- rst=1 → state IDLE and both counts 0 at the next edge. This overrides start and abort, and applies in any state, including mid-run.
- Reset values: net_rst=1, source_on=0, measure=0, busy=0, done=0, phase=0, inj_count=0, ej_count=0.
- start sampled at edge k in IDLE: phase=1 and net_rst=1 from cycle k+1.
- Valid bits sampled at edge k are reflected in the counts from cycle k+1.
- Phase boundaries are gapless: the last MEASURE cycle is counted, and the first COOLDOWN cycle is counted for ej only.
- Simultaneous start and abort in DONE → IDLE.

## Test plan
Parameters for all scenarios: PORTS=4, RESET=2, WARMUP=3, MEASURE=4, COOLDOWN=2, CNT_W=32 unless noted.
- Full run: start at cycle 0, inj_valid=4'b1111 and ej_valid=4'b0011 throughout → net_rst high in cycles 1-2, WARMUP 3-5, MEASURE 6-9, COOLDOWN 10-11, done=1 from cycle 12; inj_count=16, ej_count=12.
- Abort mid-MEASURE: abort in cycle 7 of the full run → IDLE at cycle 8 with net_rst=1 and measure=0; inj_count=8.
- start while busy: start pulses in cycles 4 and 8 → timeline identical to the full run.
- Saturation: CNT_W=4, inj_valid=4'b1111 → inj_count=15 at DONE, not 0.
- rst mid-COOLDOWN: rst in cycle 10 → phase=0, both counts 0 at cycle 11, net_rst=1.
- Restart from DONE: start in cycle 14 → counts 0 at cycle 15, then the full sequence repeats with identical results.
